hazard_scoreboard: RTL and testbench

Parametrised successor of the pipeline hazard detector. It replaces pairwise register compares with a per-register countdown scoreboard.
- Decode supplies, per instruction, the stage at which each source operand is consumed and the stage at which the result becomes forwardable.
- The block stalls ID until every used source is ready.
- It undoes the scoreboard entry of a flushed instruction and counts stall cycles.
- It sits beside the ID stage and drives the IF/ID hold and ID/EX bubble.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_sb_entry.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 141 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the register hazard scoreboard.
// Stage codes name the pipeline stage at which an operand is consumed or a result is forwardable.
package hazard_pkg;

    localparam int NUM_REGS_D = 32;
    localparam int REG_W_D    = 5;
    localparam int MAX_LAT_D  = 3;
    localparam int STAGE_W_D  = 2;
    localparam int CNT_W_D    = 32;

    // Countdown values are carried through sat_dec at this width, so any STAGE_W up to 8 fits.
    localparam int SAT_W = 8;

    localparam logic [1:0] STG_ID  = 2'd0;
    localparam logic [1:0] STG_EX  = 2'd1;
    localparam logic [1:0] STG_MEM = 2'd2;
    localparam logic [1:0] STG_WB  = 2'd3;

    function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
        logic [SAT_W-1:0] res;
        if (v == 8'd0) begin
            res = 8'd0;
        end else begin
            res = v - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: the remaining cycles before a register's pending result can be forwarded.
// It counts down to zero, reloads on issue, and takes the restore value when a flush undoes an issue.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int STAGE_W = STAGE_W_D
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [STAGE_W-1:0] i_load_val,
    input  logic               i_restore,
    input  logic [STAGE_W-1:0] i_restore_val,
    output logic [STAGE_W-1:0] o_cnt
);

    logic [STAGE_W-1:0] r_cnt;
    logic [STAGE_W-1:0] w_cnt_nxt;

    // Restore and load never coincide because a flush blocks issue; restore is checked first regardless.
    always_comb begin
        w_cnt_nxt = STAGE_W'(sat_dec(SAT_W'(r_cnt)));
        if (i_restore) begin
            w_cnt_nxt = i_restore_val;
        end else if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else begin
            w_cnt_nxt = STAGE_W'(sat_dec(SAT_W'(r_cnt)));
        end
    end

    // Countdown register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {STAGE_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard detector beside ID: stalls until every used source is forwardable,
// undoes the scoreboard write of an instruction flushed out of EX, and counts stalled cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int REG_W    = REG_W_D,
    parameter int MAX_LAT  = MAX_LAT_D,
    parameter int STAGE_W  = STAGE_W_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_id_valid,
    input  logic [REG_W-1:0]    i_id_rs,
    input  logic [REG_W-1:0]    i_id_rt,
    input  logic                i_rs_used,
    input  logic                i_rt_used,
    input  logic [STAGE_W-1:0]  i_rs_stage,
    input  logic [STAGE_W-1:0]  i_rt_stage,
    input  logic                i_id_wr_en,
    input  logic [REG_W-1:0]    i_id_rd,
    input  logic [STAGE_W-1:0]  i_id_res_stage,
    input  logic                i_flush,
    input  logic                i_stat_clr,
    output logic                o_stall,
    output logic                o_stall_rs,
    output logic                o_stall_rt,
    output logic [NUM_REGS-1:0] o_busy_mask,
    output logic [CNT_W-1:0]    o_stall_cycles
);

    logic [STAGE_W-1:0] w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [STAGE_W-1:0] w_rs_cnt;
    logic [STAGE_W-1:0] w_rt_cnt;
    logic               w_stall_rs;
    logic               w_stall_rt;
    logic               w_stall;
    logic               w_issue;
    logic               w_issue_wr;
    logic               w_restore;
    logic [STAGE_W-1:0] w_restore_val;
    logic [31:0]        w_res_ext;
    logic [STAGE_W-1:0] w_res_clamped;

    logic               r_sh_valid;
    logic [REG_W-1:0]   r_sh_rd;
    logic [STAGE_W-1:0] r_sh_prev;
    logic [CNT_W-1:0]   r_stall_cycles;

    assign w_cnt[0] = {STAGE_W{1'b0}};

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_entry
            hazard_sb_entry #(
                .STAGE_W(STAGE_W)
            ) u_entry (
                .i_clk        (i_clk),
                .i_rst_n      (i_rst_n),
                .i_load       (w_issue_wr && (i_id_rd == REG_W'(g))),
                .i_load_val   (w_res_clamped),
                .i_restore    (w_restore && (r_sh_rd == REG_W'(g))),
                .i_restore_val(w_restore_val),
                .o_cnt        (w_cnt[g])
            );
        end
    endgenerate

    // Busy mask: a register is busy while its countdown has not reached zero.
    always_comb begin
        w_busy = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            w_busy[r] = (w_cnt[r] != {STAGE_W{1'b0}});
        end
    end

    assign w_rs_cnt = w_cnt[i_id_rs];
    assign w_rt_cnt = w_cnt[i_id_rt];

    // A source stalls when its producer needs more cycles than the consumer has until its use stage.
    always_comb begin
        w_stall_rs = i_id_valid && i_rs_used && (i_id_rs != {REG_W{1'b0}}) &&
                     (w_rs_cnt > i_rs_stage) && !i_flush;
        w_stall_rt = i_id_valid && i_rt_used && (i_id_rt != {REG_W{1'b0}}) &&
                     (w_rt_cnt > i_rt_stage) && !i_flush;
        w_stall    = w_stall_rs || w_stall_rt;
    end

    assign w_issue    = i_id_valid && !w_stall && !i_flush;
    assign w_issue_wr = w_issue && i_id_wr_en && (i_id_rd != {REG_W{1'b0}});
    assign w_restore  = i_flush && r_sh_valid;
    // The shadow holds the old producer's count as seen one cycle later; one more step lands on the flush-cycle value.
    assign w_restore_val = STAGE_W'(sat_dec(SAT_W'(r_sh_prev)));
    assign w_res_ext  = 32'(i_id_res_stage);

    // Producer latency clamp.
    always_comb begin
        if (w_res_ext > 32'(MAX_LAT)) begin
            w_res_clamped = STAGE_W'(MAX_LAT);
        end else begin
            w_res_clamped = i_id_res_stage;
        end
    end

    // Shadow of the most recent scoreboard write, kept for one cycle so a flush can undo it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_valid <= 1'b0;
            r_sh_rd    <= {REG_W{1'b0}};
            r_sh_prev  <= {STAGE_W{1'b0}};
        end else if (w_issue_wr) begin
            r_sh_valid <= 1'b1;
            r_sh_rd    <= i_id_rd;
            r_sh_prev  <= STAGE_W'(sat_dec(SAT_W'(w_cnt[i_id_rd])));
        end else begin
            r_sh_valid <= 1'b0;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (i_stat_clr) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign o_stall        = w_stall;
    assign o_stall_rs     = w_stall_rs;
    assign o_stall_rt     = w_stall_rt;
    assign o_busy_mask    = w_busy;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, random traffic against an availability-time model,
// then counter saturation/clear and asynchronous reset during a stall.
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int ML = 3;
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs_used, rt_used, wr_en, flush, stat_clr;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [1:0]    rs_stage, rt_stage, res_stage;
    logic          stall, stall_rs, stall_rt;
    logic [NR-1:0] busy_mask;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_W(5), .MAX_LAT(ML), .STAGE_W(2), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_rs_used(rs_used), .i_rt_used(rt_used),
        .i_rs_stage(rs_stage), .i_rt_stage(rt_stage), .i_id_wr_en(wr_en),
        .i_id_rd(id_rd), .i_id_res_stage(res_stage), .i_flush(flush),
        .i_stat_clr(stat_clr), .o_stall(stall), .o_stall_rs(stall_rs),
        .o_stall_rt(stall_rt), .o_busy_mask(busy_mask), .o_stall_cycles(stall_cycles)
    );

    typedef struct {
        bit valid; int rs; bit rsu; int rss; int rt; bit rtu; int rts;
        bit wr; int rd; int res; bit flush; bit clr;
        bit tab; bit es; bit ers; bit ert;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    // Model: absolute cycle at which each register's result becomes forwardable.
    longint now = 0;
    longint avail [NR];
    bit     sh_v = 1'b0;
    int     sh_rd = 0;
    longint sh_old = 0;
    int     scnt = 0;
    vec_t   tbl [$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, now, act, exp);
        end
    endtask

    function automatic int rem(input int r);
        if (r == 0) return 0;
        if (avail[r] > now) return int'(avail[r] - now);
        return 0;
    endfunction

    // rs/rt/rd < 0 mean "not used" / "no write".
    function automatic vec_t op(input bit valid, input int rs, input int rss, input int rt,
                                input int rts, input int rd, input int res, input bit fl,
                                input bit es, input bit ers, input bit ert);
        vec_t v;
        v.valid = valid; v.rsu = (rs >= 0); v.rs = (rs < 0) ? 0 : rs; v.rss = rss;
        v.rtu = (rt >= 0); v.rt = (rt < 0) ? 0 : rt; v.rts = rts;
        v.wr = (rd >= 0); v.rd = (rd < 0) ? 0 : rd; v.res = res;
        v.flush = fl; v.clr = 1'b0; v.tab = 1'b1; v.es = es; v.ers = ers; v.ert = ert;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs = 5'(v.rs); rs_used = v.rsu; rs_stage = 2'(v.rss);
        id_rt = 5'(v.rt); rt_used = v.rtu; rt_stage = 2'(v.rts);
        wr_en = v.wr; id_rd = 5'(v.rd); res_stage = 2'(v.res);
        flush = v.flush; stat_clr = v.clr;
    endtask

    task automatic step(input vec_t v);
        bit m_rs, m_rt, m_st, iss;
        logic [NR-1:0] mb;
        drive(v);
        #1;
        m_rs = v.valid && v.rsu && (v.rs != 0) && (rem(v.rs) > v.rss) && !v.flush;
        m_rt = v.valid && v.rtu && (v.rt != 0) && (rem(v.rt) > v.rts) && !v.flush;
        m_st = m_rs || m_rt;
        for (int r = 0; r < NR; r++) mb[r] = (rem(r) != 0);
        chk("stall", stall, m_st);
        chk("stall_rs", stall_rs, m_rs);
        chk("stall_rt", stall_rt, m_rt);
        chk("busy_mask", busy_mask, mb);
        chk("stall_cycles", stall_cycles, scnt);
        if (v.tab) begin
            chk("tab_stall", stall, v.es);
            chk("tab_stall_rs", stall_rs, v.ers);
            chk("tab_stall_rt", stall_rt, v.ert);
        end
        @(posedge clk);
        iss = v.valid && !m_st && !v.flush;
        if (v.clr) scnt = 0;
        else if (m_st && scnt < CMAX) scnt++;
        if (v.flush && sh_v) avail[sh_rd] = sh_old;
        if (iss && v.wr && v.rd != 0) begin
            sh_old = avail[v.rd];
            avail[v.rd] = now + 1 + ((v.res > ML) ? ML : v.res);
            sh_v = 1'b1;
            sh_rd = v.rd;
        end else begin
            sh_v = 1'b0;
        end
        now++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) avail[r] = 0;
        sh_v = 1'b0;
        scnt = 0;
    endtask

    initial begin
        vec_t idle, v;
        idle = op(1'b0, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        rst_n = 1'b0;
        drive(idle);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_cycles", stall_cycles, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU r5 -> EX consumer: no bubble
        tbl.push_back(op(1, -1, 0, -1, 0, 5, 1, 0, 0, 0, 0));
        tbl.push_back(op(1, 5, 1, -1, 0, 10, 1, 0, 0, 0, 0));
        tbl.push_back(idle);
        // LW r8 -> EX consumer: one bubble
        tbl.push_back(op(1, -1, 0, -1, 0, 8, 2, 0, 0, 0, 0));
        tbl.push_back(op(1, 8, 1, -1, 0, 11, 1, 0, 1, 1, 0));
        tbl.push_back(op(1, 8, 1, -1, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(idle);
        // LW r9 -> branch: two bubbles; ALU r9 -> branch: one
        tbl.push_back(op(1, -1, 0, -1, 0, 9, 2, 0, 0, 0, 0));
        tbl.push_back(op(1, 9, 0, 3, 0, -1, 0, 0, 1, 1, 0));
        tbl.push_back(op(1, 9, 0, 3, 0, -1, 0, 0, 1, 1, 0));
        tbl.push_back(op(1, 9, 0, 3, 0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, 9, 1, 0, 0, 0, 0));
        tbl.push_back(op(1, 9, 0, 3, 0, -1, 0, 0, 1, 1, 0));
        tbl.push_back(op(1, 9, 0, 3, 0, -1, 0, 0, 0, 0, 0));
        // r0 never busy; rt path
        tbl.push_back(op(1, -1, 0, -1, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(op(1, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, 7, 2, 0, 0, 0, 0));
        tbl.push_back(op(1, 0, 0, 7, 1, -1, 0, 0, 1, 0, 1));
        tbl.push_back(op(1, 0, 0, 7, 1, -1, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        // LW r4, ALU r4, flush (kills branch reading r4), consumer
        tbl.push_back(op(1, -1, 0, -1, 0, 4, 2, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(op(1, 4, 0, -1, 0, -1, 0, 1, 0, 0, 0));
        tbl.push_back(op(1, 4, 1, -1, 0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        // long load then flushed ALU: older latency restored -> branch stalls once
        tbl.push_back(op(1, -1, 0, -1, 0, 4, 3, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, -1, 0, 1, 0, 0, 0));
        tbl.push_back(op(1, 4, 0, -1, 0, -1, 0, 0, 1, 1, 0));
        tbl.push_back(op(1, 4, 0, -1, 0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        // WAW: newest producer wins
        tbl.push_back(op(1, -1, 0, -1, 0, 6, 3, 0, 0, 0, 0));
        tbl.push_back(op(1, -1, 0, -1, 0, 6, 1, 0, 0, 0, 0));
        tbl.push_back(op(1, 6, 1, -1, 0, -1, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            v.valid = ($urandom_range(9) < 8);
            v.rs = $urandom_range(7); v.rsu = $urandom_range(1); v.rss = $urandom_range(3);
            v.rt = $urandom_range(7); v.rtu = $urandom_range(1); v.rts = $urandom_range(3);
            v.wr = ($urandom_range(9) < 7); v.rd = $urandom_range(7); v.res = $urandom_range(3);
            v.flush = ($urandom_range(9) == 0); v.clr = ($urandom_range(29) == 0);
            v.tab = 1'b0; v.es = 1'b0; v.ers = 1'b0; v.ert = 1'b0;
            step(v);
        end

        // Stall-counter saturation and clear
        v = idle; v.clr = 1'b1; v.tab = 1'b0;
        step(v);
        step(op(1, -1, 0, -1, 0, 2, 3, 0, 0, 0, 0));
        v = op(1, 2, 0, -1, 0, 2, 3, 0, 0, 0, 0); v.tab = 1'b0;
        for (int i = 0; i < 16; i++) step(v);
        chk("sat_cycles", stall_cycles, 7);
        v = idle; v.clr = 1'b1; v.tab = 1'b0;
        step(v);
        chk("clr_cycles", stall_cycles, 0);

        // Async reset in the middle of a stall
        step(op(1, -1, 0, -1, 0, 2, 3, 0, 0, 0, 0));
        v = op(1, 2, 0, -1, 0, -1, 0, 0, 0, 0, 0);
        drive(v);
        #1;
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", stall, 0);
        chk("async_rst_busy", busy_mask, 0);
        chk("async_rst_cycles", stall_cycles, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(v);
        step(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
